range_window_sequencer: RTL

- Controller that sequences a RangeFinder instance (WIDTH-bit, go/finish protocol).
- Accepts a valid/ready sample stream and groups samples into windows of WINDOW_LEN, or shorter windows ended by flush.
- Drives rf_go/rf_data/rf_finish, captures rf_range/rf_error, and returns one result per window on a valid/ready result port.
- Sits between my_chip pin logic and rf_inst.

---
 rtl/range_window_sequencer_if.sv | 42 ++++
 rtl/range_window_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/range_window_sequencer_if.sv
// ============================================================
// range_window_sequencer_if : sample, RangeFinder and result signals
// Revision 1.0
// ============================================================
`default_nettype none

interface range_window_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             flush;
  logic             rf_go;
  logic             rf_finish;
  logic [WIDTH-1:0] rf_data;
  logic [WIDTH-1:0] rf_range;
  logic             rf_error;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_range;
  logic [CW-1:0]    res_count;
  logic             res_error;
  logic             err_sticky;
  logic [15:0]      windows_done;
  logic             busy;

  modport slave (
    input  s_valid, s_data, flush, rf_range, rf_error, res_ready,
    output s_ready, rf_go, rf_finish, rf_data, res_valid, res_range,
           res_count, res_error, err_sticky, windows_done, busy
  );

  modport master (
    output s_valid, s_data, flush, rf_range, rf_error, res_ready,
    input  s_ready, rf_go, rf_finish, rf_data, res_valid, res_range,
           res_count, res_error, err_sticky, windows_done, busy
  );
endinterface

`default_nettype wire

// File: rtl/range_window_sequencer.sv
// ============================================================
// range_window_sequencer : groups a sample stream into RangeFinder windows
// Revision 1.0
// ============================================================
`default_nettype none

module range_window_sequencer #(
  parameter int WIDTH      = 16,
  parameter int WINDOW_LEN = 8,
  parameter int CW         = $clog2(WINDOW_LEN + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  range_window_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN  = 3'd1;
  localparam logic [2:0] LAST = 3'd2;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW_LEN - 1);

  logic [2:0]       r_state;
  logic [CW-1:0]    r_count;
  logic             r_rf_go;
  logic             r_rf_finish;
  logic [WIDTH-1:0] r_rf_data;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_range;
  logic [CW-1:0]    r_res_count;
  logic             r_res_error;
  logic             r_err_sticky;
  logic [15:0]      r_windows_done;

  logic w_s_ready;
  logic w_accept;

  assign w_s_ready = (r_state == IDLE) || (r_state == RUN);
  assign w_accept  = bus.s_valid & w_s_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_rf_go        <= 1'b0;
      r_rf_finish    <= 1'b0;
      r_rf_data      <= '0;
      r_res_valid    <= 1'b0;
      r_res_range    <= '0;
      r_res_count    <= '0;
      r_res_error    <= 1'b0;
      r_err_sticky   <= 1'b0;
      r_windows_done <= 16'd0;
    end else begin
      // go and finish are single-cycle pulses, re-armed only by transitions
      r_rf_go     <= 1'b0;
      r_rf_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rf_data <= bus.s_data;
            r_rf_go   <= 1'b1;
            r_count   <= CW'(1);
            r_state   <= RUN;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_rf_data <= bus.s_data;
            r_count   <= r_count + CW'(1);
            if ((r_count == LAST_IDX) || bus.flush) begin
              r_rf_finish <= 1'b1;
              r_state     <= LAST;
            end
          end else if (bus.flush) begin
            r_rf_finish <= 1'b1;
            r_state     <= LAST;
          end
        end
        LAST: r_state <= CAPT;
        CAPT: begin
          r_res_range  <= bus.rf_range;
          r_res_error  <= bus.rf_error;
          r_res_count  <= r_count;
          r_err_sticky <= r_err_sticky | bus.rf_error;
          r_res_valid  <= 1'b1;
          r_state      <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            r_res_valid    <= 1'b0;
            r_windows_done <= r_windows_done + 16'd1;
            r_count        <= '0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.rf_go        = r_rf_go;
  assign bus.rf_finish    = r_rf_finish;
  assign bus.rf_data      = r_rf_data;
  assign bus.res_valid    = r_res_valid;
  assign bus.res_range    = r_res_range;
  assign bus.res_count    = r_res_count;
  assign bus.res_error    = r_res_error;
  assign bus.err_sticky   = r_err_sticky;
  assign bus.windows_done = r_windows_done;
  assign bus.busy         = (r_state != IDLE);

endmodule

`default_nettype wire
